// File: rtl/tdm_demux12.sv
// tdm_demux12: receive-side 2:1 demux. Collects one channel-a and one
// channel-b word per frame from a tagged input stream and presents the
// pair on a valid/ready output handshake.
// Optional feature macro: DEMUX_FRAME_CNT_EN adds an 8-bit frame_cnt output
// that counts output handshakes.
module tdm_demux12 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         dup_err,
`ifdef DEMUX_FRAME_CNT_EN
  output logic [7:0]   frame_cnt,
`endif
  input  logic         clr_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    HAVE_B = 2'd2,
    FULL   = 2'd3
  } state_e;

  state_e         state_q;
  logic [W-1:0]   out_a_q;
  logic [W-1:0]   out_b_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           dup_err_q;
  logic           accept;
  logic           consume;

  // Handshake qualifiers; in_ready/out_valid are flops, so no comb path from out_ready.
  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  // Frame assembly FSM with registered data, handshake and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_a_q     <= '0;
      out_b_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      // Clear first so that a duplicate in the same cycle overrides it.
      if (clr_err) begin
        dup_err_q <= 1'b0;
      end
      case (state_q)
        EMPTY: begin
          if (accept) begin
            if (in_sel) begin
              out_b_q <= in_data;
              state_q <= HAVE_B;
            end else begin
              out_a_q <= in_data;
              state_q <= HAVE_A;
            end
          end
        end
        HAVE_A: begin
          if (accept) begin
            if (in_sel) begin
              out_b_q     <= in_data;
              state_q     <= FULL;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              out_a_q   <= in_data;
              dup_err_q <= 1'b1;
            end
          end
        end
        HAVE_B: begin
          if (accept) begin
            if (!in_sel) begin
              out_a_q     <= in_data;
              state_q     <= FULL;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              out_b_q   <= in_data;
              dup_err_q <= 1'b1;
            end
          end
        end
        FULL: begin
          if (consume) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign dup_err   = dup_err_q;

`ifdef DEMUX_FRAME_CNT_EN
  logic [CNT_W-1:0] frame_cnt_q;

  // Count completed output handshakes, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (consume) begin
      frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_tdm_demux12.sv
// Directed testbench for tdm_demux12. Build with +define+DEMUX_FRAME_CNT_EN
// to also exercise the frame counter.
module tb_tdm_demux12;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         out_valid;
  logic         out_ready;
  logic         dup_err;
  logic         clr_err;
`ifdef DEMUX_FRAME_CNT_EN
  logic [7:0]   frame_cnt;
`endif

  int passed = 0;
  int total  = 0;

  tdm_demux12 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dup_err   (dup_err),
`ifdef DEMUX_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive(1'b0, 1'b0, 4'h0); out_ready = 1'b0; clr_err = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    total++; if (out_a !== 4'h0) $display("FAIL reset_out_a got %h want %h", out_a, 4'h0); else passed++;
    total++; if (out_b !== 4'h0) $display("FAIL reset_out_b got %h want %h", out_b, 4'h0); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (dup_err !== 1'b0) $display("FAIL reset_dup_err got %b want 0", dup_err); else passed++;
  endtask

  task automatic test_normal();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'h3); step();
    total++; if (out_a !== 4'h3) $display("FAIL normal_a_capture got %h want 3", out_a); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL normal_half_valid got %b want 0", out_valid); else passed++;
    drive(1'b1, 1'b1, 4'hC); step();
    total++; if (out_valid !== 1'b1) $display("FAIL normal_valid got %b want 1", out_valid); else passed++;
    total++; if (out_a !== 4'h3 || out_b !== 4'hC) $display("FAIL normal_pair got %h/%h want 3/c", out_a, out_b); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL normal_full_ready got %b want 0", in_ready); else passed++;
    drive(1'b0, 1'b0, 4'h0); step();
    total++; if (out_valid !== 1'b0) $display("FAIL normal_valid_one_cycle got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL normal_ready_after got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 4'h5); step();
    drive(1'b1, 1'b0, 4'hA); step();
    // Keep offering junk words; FULL must ignore them.
    drive(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); else passed++;
      total++; if (out_a !== 4'hA || out_b !== 4'h5) $display("FAIL bp_pair[%0d] got %h/%h want a/5", i, out_a, out_b); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); else passed++;
      if (i < 3) step();
    end
    out_ready = 1'b1; drive(1'b0, 1'b0, 4'h0); step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got valid=%b ready=%b want 0/1", out_valid, in_ready); else passed++;
    total++; if (out_a !== 4'hA || out_b !== 4'h5) $display("FAIL bp_keep_data got %h/%h want a/5", out_a, out_b); else passed++;
  endtask

  task automatic test_duplicate();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h1); step();
    total++; if (dup_err !== 1'b0) $display("FAIL dup_before got %b want 0", dup_err); else passed++;
    drive(1'b1, 1'b0, 4'h7); step();
    total++; if (dup_err !== 1'b1) $display("FAIL dup_set got %b want 1", dup_err); else passed++;
    total++; if (out_a !== 4'h7 || out_valid !== 1'b0) $display("FAIL dup_overwrite got a=%h valid=%b want 7/0", out_a, out_valid); else passed++;
    drive(1'b1, 1'b1, 4'h9); step();
    total++; if (out_valid !== 1'b1 || out_a !== 4'h7 || out_b !== 4'h9) $display("FAIL dup_frame got v=%b %h/%h want 1 7/9", out_valid, out_a, out_b); else passed++;
    drive(1'b0, 1'b0, 4'h0); out_ready = 1'b1; step();
    out_ready = 1'b0;
    total++; if (dup_err !== 1'b1) $display("FAIL dup_sticky got %b want 1", dup_err); else passed++;
    clr_err = 1'b1; step(); clr_err = 1'b0;
    total++; if (dup_err !== 1'b0) $display("FAIL dup_clear got %b want 0", dup_err); else passed++;
    // b-side duplicate coincident with clr_err: set must win.
    drive(1'b1, 1'b1, 4'h4); step();
    drive(1'b1, 1'b1, 4'h6); clr_err = 1'b1; step(); clr_err = 1'b0;
    total++; if (dup_err !== 1'b1) $display("FAIL dup_set_wins got %b want 1", dup_err); else passed++;
    total++; if (out_b !== 4'h6 || out_valid !== 1'b0) $display("FAIL dup_b_overwrite got b=%h valid=%b want 6/0", out_b, out_valid); else passed++;
    drive(1'b1, 1'b0, 4'h8); step();
    drive(1'b0, 1'b0, 4'h0); out_ready = 1'b1; step();
    clr_err = 1'b1; step(); clr_err = 1'b0;
    total++; if (dup_err !== 1'b0) $display("FAIL dup_clear2 got %b want 0", dup_err); else passed++;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'hF); step();
    total++; if (out_a !== 4'hF) $display("FAIL mr_capture got %h want f", out_a); else passed++;
    drive(1'b0, 1'b0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_a !== 4'h0) $display("FAIL mr_async_a got %h want 0", out_a); else passed++;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL mr_async_hs got ready=%b valid=%b want 1/0", in_ready, out_valid); else passed++;
    step();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 4'h2); step();
    drive(1'b0, 1'b0, 4'h0);
    total++; if (out_valid !== 1'b0 || out_b !== 4'h2 || out_a !== 4'h0) $display("FAIL mr_have_b got v=%b %h/%h want 0 0/2", out_valid, out_a, out_b); else passed++;
    // Partial frame was discarded, so one a-word completes the frame.
    drive(1'b1, 1'b0, 4'hD); step();
    drive(1'b0, 1'b0, 4'h0);
    total++; if (out_valid !== 1'b1 || out_a !== 4'hD || out_b !== 4'h2) $display("FAIL mr_complete got v=%b %h/%h want 1 d/2", out_valid, out_a, out_b); else passed++;
    step();
  endtask

`ifdef DEMUX_FRAME_CNT_EN
  task automatic test_frame_cnt();
    rst_n = 1'b0; drive(1'b0, 1'b0, 4'h0); out_ready = 1'b1; clr_err = 1'b0;
    step(); rst_n = 1'b1; step();
    total++; if (frame_cnt !== 8'd0) $display("FAIL fc_reset got %0d want 0", frame_cnt); else passed++;
    for (int f = 1; f <= 257; f++) begin
      drive(1'b1, 1'b0, 4'(f)); step();
      drive(1'b1, 1'b1, 4'(f + 1)); step();
      drive(1'b1, 1'b0, 4'h0); step();
      if (f == 255) begin
        total++; if (frame_cnt !== 8'd255) $display("FAIL fc_255 got %0d want 255", frame_cnt); else passed++;
      end else if (f == 256) begin
        total++; if (frame_cnt !== 8'd0) $display("FAIL fc_wrap got %0d want 0", frame_cnt); else passed++;
      end
    end
    drive(1'b0, 1'b0, 4'h0);
    total++; if (frame_cnt !== 8'd1) $display("FAIL fc_257 got %0d want 1", frame_cnt); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_duplicate();
    test_mid_reset();
`ifdef DEMUX_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
